associative_memory: RTL and testbench

- Classification stage directly downstream of the temporal encoder.
- Accepts one n-gram query hypervector and compares it against NUM_CLASSES stored class prototypes by Hamming distance.
- Returns the index of the nearest prototype and its distance.
- Prototypes are loaded through a simple write port. Distance is computed CHUNK_WIDTH bits per cycle to bound popcount area.

---
 rtl/associative_memory_pkg.sv | 23 ++
 rtl/associative_memory_hamming_chunk.sv | 23 ++
 rtl/associative_memory.sv | 183 ++++++++++++++++++
 tb/tb_associative_memory.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/associative_memory_pkg.sv
// Shared dimensions and width helpers for the associative-memory classifier.
package associative_memory_pkg;

  localparam int AM_HV_DIMENSION = 2000;
  localparam int AM_NUM_CLASSES  = 5;
  localparam int AM_CHUNK_WIDTH  = 100;
  localparam int AM_NUM_CHUNKS   = AM_HV_DIMENSION / AM_CHUNK_WIDTH;

  function automatic int am_clog2_min1(input int value);
    int r;
    r = $clog2(value);
    return (r < 1) ? 1 : r;
  endfunction

  // Width able to hold a count from 0 to 'value' inclusive.
  function automatic int am_count_width(input int value);
    return am_clog2_min1(value + 1);
  endfunction

  localparam int AM_CLASS_WIDTH = am_clog2_min1(AM_NUM_CLASSES);
  localparam int AM_DIST_WIDTH  = am_count_width(AM_HV_DIMENSION);

endpackage

// File: rtl/associative_memory_hamming_chunk.sv
// Combinational Hamming distance between two equal-width chunks.
module associative_memory_hamming_chunk
  import associative_memory_pkg::*;
#(
  parameter  int CHUNK_WIDTH = AM_CHUNK_WIDTH,
  localparam int PC_WIDTH    = am_count_width(CHUNK_WIDTH)
) (
  input  logic [CHUNK_WIDTH-1:0] a_i,
  input  logic [CHUNK_WIDTH-1:0] b_i,
  output logic [PC_WIDTH-1:0]    count_o
);

  logic [CHUNK_WIDTH-1:0] diff;

  always_comb begin
    diff    = a_i ^ b_i;
    count_o = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      count_o = count_o + PC_WIDTH'(diff[i]);
    end
  end

endmodule

// File: rtl/associative_memory.sv
// Nearest-prototype classifier: scans every stored class chunk by chunk and
// reports the class with the smallest Hamming distance to the query.
module associative_memory
  import associative_memory_pkg::*;
#(
  parameter  int HV_DIMENSION = AM_HV_DIMENSION,
  parameter  int NUM_CLASSES  = AM_NUM_CLASSES,
  parameter  int CHUNK_WIDTH  = AM_CHUNK_WIDTH,
  localparam int CLASS_WIDTH  = am_clog2_min1(NUM_CLASSES),
  localparam int DIST_WIDTH   = am_count_width(HV_DIMENSION)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hvin_valid,
  output logic                    hvin_ready,
  input  logic [HV_DIMENSION-1:0] hvin,
  input  logic                    proto_we,
  output logic                    proto_ready,
  input  logic [CLASS_WIDTH-1:0]  proto_addr,
  input  logic [HV_DIMENSION-1:0] proto_data,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [CLASS_WIDTH-1:0]  dout_class,
  output logic [DIST_WIDTH-1:0]   dout_dist
);

  localparam int NUM_CHUNKS  = HV_DIMENSION / CHUNK_WIDTH;
  localparam int CHUNK_IDX_W = am_clog2_min1(NUM_CHUNKS);
  localparam int PC_WIDTH    = am_count_width(CHUNK_WIDTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic [CLASS_WIDTH-1:0] LAST_CLASS = CLASS_WIDTH'(NUM_CLASSES - 1);
  localparam logic [CHUNK_IDX_W-1:0] LAST_CHUNK = CHUNK_IDX_W'(NUM_CHUNKS - 1);

  logic [1:0]             state_q, state_d;
  logic [CLASS_WIDTH-1:0] cls_q, cls_d;
  logic [CHUNK_IDX_W-1:0] chunk_q, chunk_d;
  logic [DIST_WIDTH-1:0]  acc_q, acc_d;
  logic [DIST_WIDTH-1:0]  best_dist_q, best_dist_d;
  logic [CLASS_WIDTH-1:0] best_class_q, best_class_d;
  logic [CLASS_WIDTH-1:0] dout_class_q, dout_class_d;
  logic [DIST_WIDTH-1:0]  dout_dist_q, dout_dist_d;
  logic                   shadow_vld_q, shadow_vld_d;

  // Storage is held chunk-wise so the compute datapath indexes it directly.
  logic [CHUNK_WIDTH-1:0] query_q  [NUM_CHUNKS];
  logic [CHUNK_WIDTH-1:0] proto_q  [NUM_CLASSES][NUM_CHUNKS];
  logic [CHUNK_WIDTH-1:0] shadow_q [NUM_CHUNKS];
  logic [CLASS_WIDTH-1:0] shadow_cls_q;

  logic                   query_fire;
  logic                   proto_wr;
  logic [CHUNK_WIDTH-1:0] proto_chunk;
  logic [PC_WIDTH-1:0]    pc;
  logic [DIST_WIDTH-1:0]  total;

  assign hvin_ready  = (state_q == IDLE);
  assign proto_ready = (state_q == IDLE);
  assign dout_valid  = (state_q == DONE);
  assign dout_class  = dout_class_q;
  assign dout_dist   = dout_dist_q;

  assign query_fire = hvin_valid && (state_q == IDLE);
  assign proto_wr   = proto_we && (state_q == IDLE) && !rst &&
                      (int'(proto_addr) < NUM_CLASSES);

  // A write landing on the query's fire edge must not be seen by that query,
  // so the overwritten entry is shadowed for the duration of the scan.
  always_comb begin
    proto_chunk = proto_q[cls_q][chunk_q];
    if (shadow_vld_q && (shadow_cls_q == cls_q)) begin
      proto_chunk = shadow_q[chunk_q];
    end
  end

  associative_memory_hamming_chunk #(
    .CHUNK_WIDTH (CHUNK_WIDTH)
  ) u_hamming_chunk (
    .a_i     (query_q[chunk_q]),
    .b_i     (proto_chunk),
    .count_o (pc)
  );

  assign total = acc_q + DIST_WIDTH'(pc);

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    chunk_d      = chunk_q;
    acc_d        = acc_q;
    best_dist_d  = best_dist_q;
    best_class_d = best_class_q;
    dout_class_d = dout_class_q;
    dout_dist_d  = dout_dist_q;
    shadow_vld_d = shadow_vld_q;
    case (state_q)
      IDLE: begin
        if (query_fire) begin
          state_d      = COMPUTE;
          cls_d        = '0;
          chunk_d      = '0;
          acc_d        = '0;
          best_dist_d  = '1;
          best_class_d = '0;
          shadow_vld_d = proto_wr;
        end
      end
      COMPUTE: begin
        if (chunk_q != LAST_CHUNK) begin
          acc_d   = total;
          chunk_d = chunk_q + CHUNK_IDX_W'(1);
        end else begin
          acc_d   = '0;
          chunk_d = '0;
          cls_d   = cls_q + CLASS_WIDTH'(1);
          // Strict compare keeps the lowest class index on a tie.
          if (total < best_dist_q) begin
            best_dist_d  = total;
            best_class_d = cls_q;
          end
          if (cls_q == LAST_CLASS) begin
            state_d      = DONE;
            cls_d        = '0;
            dout_class_d = best_class_d;
            dout_dist_d  = best_dist_d;
          end
        end
      end
      DONE: begin
        if (dout_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cls_q        <= '0;
      chunk_q      <= '0;
      acc_q        <= '0;
      best_dist_q  <= '0;
      best_class_q <= '0;
      dout_class_q <= '0;
      dout_dist_q  <= '0;
      shadow_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      chunk_q      <= chunk_d;
      acc_q        <= acc_d;
      best_dist_q  <= best_dist_d;
      best_class_q <= best_class_d;
      dout_class_q <= dout_class_d;
      dout_dist_q  <= dout_dist_d;
      shadow_vld_q <= shadow_vld_d;
    end
  end

  // Query, prototype and shadow storage are data only and survive reset.
  always_ff @(posedge clk) begin
    if (query_fire) begin
      for (int k = 0; k < NUM_CHUNKS; k++) begin
        query_q[k] <= hvin[k*CHUNK_WIDTH +: CHUNK_WIDTH];
      end
    end
    if (query_fire && proto_wr) begin
      shadow_q     <= proto_q[proto_addr];
      shadow_cls_q <= proto_addr;
    end
    if (proto_wr) begin
      for (int k = 0; k < NUM_CHUNKS; k++) begin
        proto_q[proto_addr][k] <= proto_data[k*CHUNK_WIDTH +: CHUNK_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_associative_memory.sv
// Self-checking bench for associative_memory against a transaction-level model.
module tb_associative_memory;
  import associative_memory_pkg::*;

  localparam int HV  = AM_HV_DIMENSION;
  localparam int NC  = AM_NUM_CLASSES;
  localparam int NCH = AM_NUM_CHUNKS;
  localparam int CW  = AM_CLASS_WIDTH;
  localparam int DW  = AM_DIST_WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          hvin_valid;
  logic          hvin_ready;
  logic [HV-1:0] hvin;
  logic          proto_we;
  logic          proto_ready;
  logic [CW-1:0] proto_addr;
  logic [HV-1:0] proto_data;
  logic          dout_valid;
  logic          dout_ready;
  logic [CW-1:0] dout_class;
  logic [DW-1:0] dout_dist;

  associative_memory dut (
    .clk         (clk),
    .rst         (rst),
    .hvin_valid  (hvin_valid),
    .hvin_ready  (hvin_ready),
    .hvin        (hvin),
    .proto_we    (proto_we),
    .proto_ready (proto_ready),
    .proto_addr  (proto_addr),
    .proto_data  (proto_data),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_class  (dout_class),
    .dout_dist   (dout_dist)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: protocol phases, a latency counter and brute-force distances.
  logic [HV-1:0] m_proto [NC];
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  int m_cnt = 0;
  int m_exp_class = 0;
  int m_exp_dist = 0;
  int m_class = 0;
  int m_dist = 0;

  function automatic int nearest_dist(input logic [HV-1:0] q);
    int best = HV + 1;
    for (int i = 0; i < NC; i++) begin
      if ($countones(q ^ m_proto[i]) < best) best = $countones(q ^ m_proto[i]);
    end
    return best;
  endfunction

  function automatic int nearest_class(input logic [HV-1:0] q);
    int best = HV + 1;
    int cls = 0;
    for (int i = 0; i < NC; i++) begin
      if ($countones(q ^ m_proto[i]) < best) begin
        best = $countones(q ^ m_proto[i]);
        cls  = i;
      end
    end
    return cls;
  endfunction

  function automatic logic [HV-1:0] flip_bits(input logic [HV-1:0] v, input int n, input int off);
    logic [HV-1:0] r;
    r = v;
    for (int j = 0; j < n; j++) r[(off + j*151) % HV] = ~r[(off + j*151) % HV];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_cnt   <= 0;
      m_class <= 0;
      m_dist  <= 0;
    end else if (m_done) begin
      if (dout_ready) m_done <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == NC*NCH - 1) begin
        m_busy  <= 1'b0;
        m_done  <= 1'b1;
        m_class <= m_exp_class;
        m_dist  <= m_exp_dist;
      end
    end else begin
      if (hvin_valid) begin
        m_busy      <= 1'b1;
        m_cnt       <= 0;
        m_exp_class <= nearest_class(hvin);
        m_exp_dist  <= nearest_dist(hvin);
      end
      if (proto_we && (int'(proto_addr) < NC)) m_proto[proto_addr] <= proto_data;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("hvin_ready", hvin_ready, !(m_busy || m_done));
      check("proto_ready", proto_ready, !(m_busy || m_done));
      check("dout_valid", dout_valid, m_done);
      check("dout_class", dout_class, m_class);
      check("dout_dist", dout_dist, m_dist);
    end
  end

  task automatic write_proto(input int a, input logic [HV-1:0] d);
    proto_we   = 1'b1;
    proto_addr = CW'(a);
    proto_data = d;
    @(posedge clk); #2;
    proto_we = 1'b0;
  endtask

  task automatic run_query(input logic [HV-1:0] q, output int fire_cyc);
    int guard = 0;
    while (!hvin_ready && guard < 300) begin
      @(posedge clk); #2;
      guard++;
    end
    check("query_ready_wait", hvin_ready, 1);
    hvin       = q;
    hvin_valid = 1'b1;
    @(posedge clk); #2;
    hvin_valid = 1'b0;
    fire_cyc   = cyc;
  endtask

  task automatic wait_valid(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dout_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #2;
    end
    check("dout_valid_timeout", ok, 1);
  endtask

  task automatic take_result();
    dout_ready = 1'b1;
    @(posedge clk); #2;
    dout_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HV-1:0] q, q2, alt, ones;
    int fc;
    rst = 1'b1; hvin_valid = 1'b0; hvin = '0; proto_we = 1'b0;
    proto_addr = '0; proto_data = '0; dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst    = 1'b0;
    chk_en = 1'b1;
    check("reset_dout_valid", dout_valid, 0);
    check("reset_hvin_ready", hvin_ready, 1);
    check("reset_proto_ready", proto_ready, 1);
    check("reset_dout_class", dout_class, 0);
    check("reset_dout_dist", dout_dist, 0);

    // Nearest is the all-ones prototype at distance 10.
    ones = '1;
    for (int i = 0; i < HV; i++) alt[i] = (i % 2 == 1);
    write_proto(0, '0);
    write_proto(1, ones);
    for (int a = 2; a < NC; a++) write_proto(a, alt);
    q = ones;
    for (int i = 0; i < 10; i++) q[i*197] = 1'b0;
    run_query(q, fc);
    wait_valid(300);
    check("latency_edges", cyc - fc, 100);
    check("basic_class", dout_class, 1);
    check("basic_dist", dout_dist, 10);
    take_result();

    // Tie between classes 2 and 3 at distance 7.
    for (int i = 0; i < HV; i++) q[i] = 1'($urandom_range(0, 1));
    write_proto(0, flip_bits(q, 30, 3));
    write_proto(1, ~q);
    write_proto(2, flip_bits(q, 7, 0));
    write_proto(3, flip_bits(q, 7, 50));
    write_proto(4, flip_bits(q, 12, 9));
    run_query(q, fc);
    wait_valid(300);
    check("tie_class", dout_class, 2);
    check("tie_dist", dout_dist, 7);
    take_result();

    // Backpressure with a competing query offered during the stall.
    run_query(q, fc);
    wait_valid(300);
    q2 = ~q;
    hvin = q2;
    hvin_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("stall_class", dout_class, 2);
      check("stall_dist", dout_dist, 7);
      check("stall_hvin_ready", hvin_ready, 0);
      @(posedge clk); #2;
    end
    dout_ready = 1'b1;
    hvin_valid = 1'b0;
    @(posedge clk); #2;
    dout_ready = 1'b0;
    check("post_fire_hvin_ready", hvin_ready, 1);
    check("post_fire_dout_valid", dout_valid, 0);

    // Prototype write during compute is dropped.
    run_query(q, fc);
    repeat (10) @(posedge clk);
    #2;
    check("compute_proto_ready", proto_ready, 0);
    write_proto(4, q);
    wait_valid(300);
    check("ignored_write_class", dout_class, 2);
    check("ignored_write_dist", dout_dist, 7);
    take_result();
    write_proto(4, q);
    run_query(q, fc);
    wait_valid(300);
    check("rewrite_class", dout_class, 4);
    check("rewrite_dist", dout_dist, 0);
    take_result();

    // Same-cycle write and query: the query sees the old entry.
    hvin = q; hvin_valid = 1'b1;
    proto_we = 1'b1; proto_addr = CW'(4); proto_data = ~q;
    @(posedge clk); #2;
    hvin_valid = 1'b0; proto_we = 1'b0;
    wait_valid(300);
    check("same_cycle_class", dout_class, 4);
    check("same_cycle_dist", dout_dist, 0);
    take_result();
    run_query(q, fc);
    wait_valid(300);
    check("after_same_cycle_class", dout_class, 2);
    check("after_same_cycle_dist", dout_dist, 7);
    take_result();

    // Reset in the middle of a scan.
    run_query(q, fc);
    repeat (36) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (150) @(posedge clk);
    #2;
    check("midreset_no_valid", dout_valid, 0);
    check("midreset_dist_cleared", dout_dist, 0);
    run_query(q, fc);
    wait_valid(300);
    check("after_reset_class", dout_class, 2);
    check("after_reset_dist", dout_dist, 7);
    take_result();

    // Randomized queries with writes, stray writes and random consumer stalls.
    for (int it = 0; it < 8; it++) begin
      int guard;
      for (int i = 0; i < HV; i++) q[i] = 1'($urandom_range(0, 1));
      for (int w = 0; w < int'($urandom_range(1, 5)); w++) begin
        write_proto(int'($urandom_range(0, 7)),
                    flip_bits(q, int'($urandom_range(0, 60)), int'($urandom_range(0, HV-1))));
      end
      run_query(q, fc);
      guard = 0;
      while ((m_busy || m_done) && guard < 400) begin
        dout_ready = 1'($urandom_range(0, 1));
        proto_we   = ($urandom_range(0, 3) == 0);
        proto_addr = CW'($urandom_range(0, 7));
        proto_data = flip_bits(q, int'($urandom_range(0, 20)), int'($urandom_range(0, HV-1)));
        @(posedge clk); #2;
        guard++;
      end
      dout_ready = 1'b0;
      proto_we   = 1'b0;
      check("rand_drain", guard < 400, 1);
    end

    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
